// File: rtl/uart_mem_pkg.sv
// Shared encodings for the UART memory/compute engine: op codes, FSM states
// and the byte-lane mapping used by both rx word assembly and tx serialisation.
package uart_mem_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_MAXU = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV_A,
        S_RECV_B,
        S_COMPUTE,
        S_SEND
    } state_t;

    // Lane 0 is bits [7:0] of the word; idx is the byte's position on the wire.
    function automatic int unsigned byte_lane(input int unsigned idx,
                                              input int unsigned nbytes,
                                              input bit          little);
        return little ? idx : (nbytes - 1 - idx);
    endfunction

endpackage

// File: rtl/uart_mem_alu.sv
// Combinational element-wise op unit; ADD/SUB wrap modulo 2^W, MAXU is unsigned.
module uart_mem_alu
    import uart_mem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    always_comb begin
        y = a + b;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            OP_MAXU: y = (a > b) ? a : b;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, and a
// one-cycle rx_dv pulse per received byte.
module uart_rx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte
);
    localparam int CNTW = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       state_q, state_d;
    logic [1:0]      sync_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            dv_q, dv_d;
    logic            rx_s;

    assign rx_s    = sync_q[1];
    assign rx_dv   = dv_q;
    assign rx_byte = shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            dv_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_serial};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            dv_q    <= dv_d;
        end
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNTW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        dv_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_q == CNTW'((CLKS_PER_BIT - 1) / 2)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    dv_d    = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with no reset: its all-zero power-up state is idle with
// the line high, and a frame in flight always runs to completion.
module uart_tx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_active,
    output logic       tx_serial,
    output logic       tx_done
);
    localparam int CNTW = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;

    assign tx_active = (state_q != TX_IDLE);
    assign tx_done   = done_q;
    assign tx_serial = (state_q == TX_START) ? 1'b0 :
                       (state_q == TX_DATA)  ? data_q[0] : 1'b1;

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bit_q   <= bit_d;
        data_q  <= data_d;
        done_q  <= done_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNTW'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (tx_dv) begin
                    data_d  = tx_byte;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                    cnt_d  = '0;
                    data_d = data_q >> 1;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (cnt_q == CNTW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_mem_engine.sv
// Receives arrays A and B over UART, applies a selectable element-wise op into
// a result array, then streams the result back over UART.
module uart_mem_engine
    import uart_mem_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 100,
    parameter int MEM_DEPTH     = 512,
    parameter int WORD_BYTES    = 4,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   op,
    input  logic                         Rx_Serial,
    output logic                         Tx_Serial,
    output logic                         busy,
    output logic                         recv_done,
    output logic                         send_done,
    output logic                         overrun,
    output logic [$clog2(MEM_DEPTH):0]   word_cnt
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WORD_BYTES) + 1;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic          overrun_q, overrun_d;
    logic          recv_done_q, recv_done_d;
    logic          send_done_q, send_done_d;
    logic          tx_wait_q, tx_wait_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [W-1:0]  asm_q, asm_d;

    logic [W-1:0]  mem_a [MEM_DEPTH];
    logic [W-1:0]  mem_b [MEM_DEPTH];
    logic [W-1:0]  mem_r [MEM_DEPTH];
    logic [W-1:0]  rd_a_q, rd_b_q, rd_r_q, alu_y;
    logic          we_a, we_b, we_r;
    logic [AW-1:0] res_idx;

    logic          rx_dv, tx_dv, tx_active, tx_done;
    logic [7:0]    rx_byte, tx_byte;
    int unsigned   lane_sh;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk), .rst(rst), .rx_serial(Rx_Serial), .rx_dv(rx_dv), .rx_byte(rx_byte)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk(clk), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active),
        .tx_serial(Tx_Serial), .tx_done(tx_done)
    );

    uart_mem_alu #(.W(W)) u_alu (.op(op_q), .a(rd_a_q), .b(rd_b_q), .y(alu_y));

    assign busy      = (state_q != S_IDLE);
    assign recv_done = recv_done_q;
    assign send_done = send_done_q;
    assign overrun   = overrun_q;
    assign word_cnt  = word_cnt_q;

    // One byte counter drives both rx assembly and tx serialisation.
    assign lane_sh = 8 * byte_lane(32'(byte_cnt_q), WORD_BYTES, LITTLE_ENDIAN != 0);
    assign asm_d   = (rx_dv && (state_q == S_RECV_A || state_q == S_RECV_B))
                   ? ((asm_q & ~(W'(8'hFF) << lane_sh)) | (W'(rx_byte) << lane_sh))
                   : asm_q;
    assign tx_byte = 8'(rd_r_q >> lane_sh);
    assign res_idx = AW'(word_cnt_q - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            overrun_q   <= 1'b0;
            recv_done_q <= 1'b0;
            send_done_q <= 1'b0;
            tx_wait_q   <= 1'b0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            overrun_q   <= overrun_d;
            recv_done_q <= recv_done_d;
            send_done_q <= send_done_d;
            tx_wait_q   <= tx_wait_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
        asm_q <= asm_d;
    end

    // Result memory is read at the next word index so rd_r_q is ready on entry.
    always_ff @(posedge clk) begin
        if (we_a) mem_a[word_cnt_q[AW-1:0]] <= asm_d;
        if (we_b) mem_b[word_cnt_q[AW-1:0]] <= asm_d;
        if (we_r) mem_r[res_idx] <= alu_y;
        rd_a_q <= mem_a[word_cnt_q[AW-1:0]];
        rd_b_q <= mem_b[word_cnt_q[AW-1:0]];
        rd_r_q <= mem_r[word_cnt_d[AW-1:0]];
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        overrun_d   = overrun_q;
        recv_done_d = 1'b0;
        send_done_d = 1'b0;
        tx_wait_d   = tx_wait_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        we_a        = 1'b0;
        we_b        = 1'b0;
        we_r        = 1'b0;
        tx_dv       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = op;
                    overrun_d  = 1'b0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    tx_wait_d  = 1'b0;
                    state_d    = S_RECV_A;
                end
            end
            S_RECV_A, S_RECV_B: begin
                if (rx_dv) begin
                    if (byte_cnt_q == BW'(WORD_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        we_a       = (state_q == S_RECV_A);
                        we_b       = (state_q == S_RECV_B);
                        if (word_cnt_q == CW'(MEM_DEPTH - 1)) begin
                            word_cnt_d  = '0;
                            recv_done_d = (state_q == S_RECV_B);
                            state_d     = (state_q == S_RECV_A) ? S_RECV_B : S_COMPUTE;
                        end else begin
                            word_cnt_d = word_cnt_q + CW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                // Write of word k-1 overlaps read of word k; one extra cycle drains it.
                we_r = (word_cnt_q != '0);
                if (word_cnt_q == CW'(MEM_DEPTH)) begin
                    word_cnt_d = '0;
                    state_d    = S_SEND;
                end else begin
                    word_cnt_d = word_cnt_q + CW'(1);
                end
            end
            S_SEND: begin
                if (!tx_wait_q) begin
                    if (!tx_active) begin
                        tx_dv     = 1'b1;
                        tx_wait_d = 1'b1;
                    end
                end else if (tx_done) begin
                    tx_wait_d = 1'b0;
                    if (byte_cnt_q == BW'(WORD_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        if (word_cnt_q == CW'(MEM_DEPTH - 1)) begin
                            word_cnt_d  = '0;
                            send_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + CW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rx_dv && (state_q == S_COMPUTE || state_q == S_SEND)) overrun_d = 1'b1;
    end

endmodule

// File: tb/tb_uart_mem_engine.sv
// Bench for uart_mem_engine: a big-endian and a little-endian instance share
// the same stimulus; each scenario task checks the instance it targets.
module tb_uart_mem_engine;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int WB    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       rx = 1'b1;

    logic       tx0, busy0, rd0, sd0, ov0;
    logic       tx1, busy1, rd1, sd1, ov1;
    logic [2:0] wc0, wc1;

    always #5 clk = ~clk;

    uart_mem_engine #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(DEPTH), .WORD_BYTES(WB), .LITTLE_ENDIAN(0)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .Rx_Serial(rx), .Tx_Serial(tx0),
        .busy(busy0), .recv_done(rd0), .send_done(sd0), .overrun(ov0), .word_cnt(wc0)
    );

    uart_mem_engine #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(DEPTH), .WORD_BYTES(WB), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .rst(rst), .start(start), .op(op), .Rx_Serial(rx), .Tx_Serial(tx1),
        .busy(busy1), .recv_done(rd1), .send_done(sd1), .overrun(ov1), .word_cnt(wc1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  txq0[$];
    logic [7:0]  txq1[$];
    int          rdc0 = 0, sdc0 = 0, rdc1 = 0, sdc1 = 0;
    logic [15:0] ja[DEPTH];
    logic [15:0] jb[DEPTH];
    logic [1:0]  jop = 2'b00;
    bit          jle = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_word(input int i);
        case (jop)
            2'b00:   return ja[i] + jb[i];
            2'b01:   return ja[i] - jb[i];
            2'b10:   return ja[i] ^ jb[i];
            default: return (ja[i] > jb[i]) ? ja[i] : jb[i];
        endcase
    endfunction

    function automatic logic [7:0] ref_byte(input int k);
        logic [15:0] w;
        int pos;
        w   = ref_word(k / WB);
        pos = k % WB;
        return jle ? 8'(w >> (8 * pos)) : 8'(w >> (8 * (WB - 1 - pos)));
    endfunction

    // ---------------- line monitors ----------------
    task automatic rx_frame(input int which, output logic [7:0] b);
        do @(negedge clk); while (((which != 0) ? tx1 : tx0) !== 1'b0);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = (which != 0) ? tx1 : tx0;
        end
        repeat (CPB) @(negedge clk);
    endtask

    always begin : mon0
        logic [7:0] b;
        rx_frame(0, b);
        txq0.push_back(b);
    end

    always begin : mon1
        logic [7:0] b;
        rx_frame(1, b);
        txq1.push_back(b);
    end

    always @(negedge clk) begin
        if (rd0) rdc0++;
        if (sd0) sdc0++;
        if (rd1) rdc1++;
        if (sd1) sdc1++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB + 2) @(negedge clk);
    endtask

    task automatic clear_obs();
        txq0.delete();
        txq1.delete();
        rdc0 = 0; sdc0 = 0; rdc1 = 0; sdc1 = 0;
    endtask

    task automatic pulse_start(input logic [1:0] o);
        @(negedge clk);
        op = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input bit arr_b, input int n);
        logic [15:0] wd;
        int sh;
        for (int w = 0; w < n; w++) begin
            for (int i = 0; i < WB; i++) begin
                wd = arr_b ? jb[w] : ja[w];
                sh = jle ? 8 * i : 8 * (WB - 1 - i);
                send_byte(8'(wd >> sh));
            end
        end
    endtask

    task automatic wait_done(input bit sel, output bit got);
        got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (((sel != 0) ? sdc1 : sdc0) != 0) begin
                got = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_job(input bit sel, output bit got);
        clear_obs();
        pulse_start(jop);
        feed(1'b0, DEPTH);
        feed(1'b1, DEPTH);
        wait_done(sel, got);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
        n_cmp++; if (rd0 !== 1'b0) begin n_fail++; $display("FAIL reset_recv_done got=%0b exp=0", rd0); end
        n_cmp++; if (sd0 !== 1'b0) begin n_fail++; $display("FAIL reset_send_done got=%0b exp=0", sd0); end
        n_cmp++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%0b exp=0", ov0); end
        n_cmp++; if (wc0 !== 3'd0) begin n_fail++; $display("FAIL reset_word_cnt got=%0d exp=0", wc0); end
        n_cmp++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%0b exp=1", tx0); end
    endtask

    task automatic test_add_wrap();
        logic [7:0] exp_b[8] = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h13, 8'h35, 8'h00, 8'h00};
        bit got;
        ja = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000};
        jb = '{16'h0002, 16'h0001, 16'h0101, 16'h8000};
        jop = 2'b00; jle = 1'b0;
        clear_obs();
        pulse_start(jop);
        n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL add_busy_rise got=%0b exp=1", busy0); end
        feed(1'b0, DEPTH);
        feed(1'b1, DEPTH);
        wait_done(1'b0, got);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL add_timeout got=%0b exp=1", got); end
        n_cmp++; if (txq0.size() != 8) begin n_fail++; $display("FAIL add_count got=%0d exp=8", txq0.size()); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (txq0[k] !== exp_b[k]) begin n_fail++; $display("FAIL add_byte%0d got=%02h exp=%02h", k, txq0[k], exp_b[k]); end
        end
        n_cmp++; if (rdc0 != 1) begin n_fail++; $display("FAIL add_recv_done got=%0d exp=1", rdc0); end
        n_cmp++; if (sdc0 != 1) begin n_fail++; $display("FAIL add_send_done got=%0d exp=1", sdc0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL add_busy_after got=%0b exp=0", busy0); end
    endtask

    task automatic test_sub_xor_maxu();
        logic [15:0] exp_w[3][DEPTH] = '{'{16'h0002, 16'hFFFF, 16'hE100, 16'hFFFF},
                                         '{16'h0006, 16'h0001, 16'hFF00, 16'hFFFF},
                                         '{16'h0005, 16'h0001, 16'hF0F0, 16'h8000}};
        logic [15:0] w;
        bit got;
        ja = '{16'h0005, 16'h0000, 16'hF0F0, 16'h7FFF};
        jb = '{16'h0003, 16'h0001, 16'h0FF0, 16'h8000};
        jle = 1'b0;
        for (int o = 1; o < 4; o++) begin
            jop = 2'(o);
            run_job(1'b0, got);
            n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL op%0d_timeout got=%0b exp=1", o, got); end
            n_cmp++; if (txq0.size() != 8) begin n_fail++; $display("FAIL op%0d_count got=%0d exp=8", o, txq0.size()); end
            for (int i = 0; i < DEPTH; i++) begin
                w = {txq0[2*i], txq0[2*i+1]};
                n_cmp++;
                if (w !== exp_w[o-1][i]) begin n_fail++; $display("FAIL op%0d_word%0d got=%04h exp=%04h", o, i, w, exp_w[o-1][i]); end
            end
        end
    endtask

    task automatic test_random();
        bit got;
        jle = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                ja[i] = 16'($urandom);
                jb[i] = 16'($urandom);
            end
            jop = 2'($urandom_range(3));
            run_job(1'b0, got);
            n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rand%0d_timeout got=%0b exp=1", r, got); end
            n_cmp++; if (txq0.size() != 8) begin n_fail++; $display("FAIL rand%0d_count got=%0d exp=8", r, txq0.size()); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (txq0[k] !== ref_byte(k)) begin n_fail++; $display("FAIL rand%0d_byte%0d op=%0d got=%02h exp=%02h", r, k, jop, txq0[k], ref_byte(k)); end
            end
        end
    endtask

    task automatic test_endian();
        logic [7:0] exp_b[2] = '{8'h35, 8'h12};
        bit got;
        for (int i = 0; i < DEPTH; i++) begin
            ja[i] = 16'h1234;
            jb[i] = 16'h0001;
        end
        jop = 2'b00; jle = 1'b1;
        run_job(1'b1, got);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL le_timeout got=%0b exp=1", got); end
        n_cmp++; if (txq1.size() != 8) begin n_fail++; $display("FAIL le_count got=%0d exp=8", txq1.size()); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (txq1[k] !== exp_b[k % 2]) begin n_fail++; $display("FAIL le_byte%0d got=%02h exp=%02h", k, txq1[k], exp_b[k % 2]); end
        end
        n_cmp++; if (rdc1 != 1) begin n_fail++; $display("FAIL le_recv_done got=%0d exp=1", rdc1); end
        jle = 1'b0;
    endtask

    task automatic test_overrun_start();
        bit got;
        bit seen;
        for (int i = 0; i < DEPTH; i++) begin
            ja[i] = 16'($urandom);
            jb[i] = 16'($urandom);
        end
        jop = 2'b10; jle = 1'b0;
        clear_obs();
        pulse_start(jop);
        feed(1'b0, DEPTH);
        feed(1'b1, DEPTH);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txq0.size() >= 1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ovr_send_phase got=%0b exp=1", seen); end
        pulse_start(2'b00);
        send_byte(8'h5A);
        n_cmp++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%0b exp=1", ov0); end
        n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL ovr_busy_in_send got=%0b exp=1", busy0); end
        wait_done(1'b0, got);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL ovr_timeout got=%0b exp=1", got); end
        repeat (200) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL ovr_no_restart got=%0b exp=0", busy0); end
        n_cmp++; if (sdc0 != 1) begin n_fail++; $display("FAIL ovr_send_done got=%0d exp=1", sdc0); end
        n_cmp++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%0b exp=1", ov0); end
        n_cmp++; if (txq0.size() != 8) begin n_fail++; $display("FAIL ovr_count got=%0d exp=8", txq0.size()); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (txq0[k] !== ref_byte(k)) begin n_fail++; $display("FAIL ovr_byte%0d got=%02h exp=%02h", k, txq0[k], ref_byte(k)); end
        end
        jop = 2'b11;
        clear_obs();
        pulse_start(jop);
        n_cmp++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%0b exp=0", ov0); end
        feed(1'b0, DEPTH);
        feed(1'b1, DEPTH);
        wait_done(1'b0, got);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL ovr2_timeout got=%0b exp=1", got); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (txq0[k] !== ref_byte(k)) begin n_fail++; $display("FAIL ovr2_byte%0d got=%02h exp=%02h", k, txq0[k], ref_byte(k)); end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        for (int i = 0; i < DEPTH; i++) begin
            ja[i] = 16'($urandom);
            jb[i] = 16'($urandom);
        end
        jop = 2'b01; jle = 1'b0;
        clear_obs();
        pulse_start(jop);
        feed(1'b0, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0b exp=0", busy0); end
        n_cmp++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx got=%0b exp=1", tx0); end
        n_cmp++; if (wc0 !== 3'd0) begin n_fail++; $display("FAIL rstmid_word_cnt got=%0d exp=0", wc0); end
        repeat (20) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_stays_idle got=%0b exp=0", busy0); end
        jop = 2'b00;
        run_job(1'b0, got);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rstmid_job_timeout got=%0b exp=1", got); end
        n_cmp++; if (rdc0 != 1) begin n_fail++; $display("FAIL rstmid_recv_done got=%0d exp=1", rdc0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (txq0[k] !== ref_byte(k)) begin n_fail++; $display("FAIL rstmid_byte%0d got=%02h exp=%02h", k, txq0[k], ref_byte(k)); end
        end
    endtask

    task automatic test_idle_byte();
        bit got;
        for (int i = 0; i < DEPTH; i++) begin
            ja[i] = 16'($urandom);
            jb[i] = 16'($urandom);
        end
        jop = 2'b00; jle = 1'b0;
        clear_obs();
        send_byte(8'hA5);
        repeat (4) @(negedge clk);
        n_cmp++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL idle_overrun got=%0b exp=0", ov0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%0b exp=0", busy0); end
        run_job(1'b0, got);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL idle_job_timeout got=%0b exp=1", got); end
        n_cmp++; if (txq0.size() != 8) begin n_fail++; $display("FAIL idle_count got=%0d exp=8", txq0.size()); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (txq0[k] !== ref_byte(k)) begin n_fail++; $display("FAIL idle_byte%0d got=%02h exp=%02h", k, txq0[k], ref_byte(k)); end
        end
        n_cmp++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL idle_overrun_after got=%0b exp=0", ov0); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_xor_maxu();
        test_random();
        test_endian();
        test_overrun_start();
        test_reset_mid();
        test_idle_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
